// File: rtl/sparc_exu_eclbyptag.sv
// Destination-tag pipeline (E/M/W, optional W2) producing one-hot operand bypass selects.
// Define SPARC_EXU_BYP_W2_EN to add the W2 stage and make select bit 4 live.
module sparc_exu_eclbyptag (
  input  logic       rclk,
  input  logic       arst_l,
  input  logic [1:0] tid_d,
  input  logic [4:0] rd_d,
  input  logic       wen_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rs3_d,
  input  logic       stall_d,
  input  logic       kill_e,
  output logic [4:0] byp_rs1_sel_d,
  output logic [4:0] byp_rs2_sel_d,
  output logic [4:0] byp_rs3_sel_d,
  output logic [3:0] tag_vld_ewm
);

  logic [6:0] r_tag_e, r_tag_m, r_tag_w;
  logic       r_vld_e, r_vld_m, r_vld_w;
  logic [6:0] w_tag_w2;
  logic       w_vld_w2;
  logic       w_accept;

  // A stalled instruction becomes a bubble; %g0 writes are never tracked.
  assign w_accept = wen_d & ~stall_d & (rd_d != 5'd0);

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_tag_e <= 7'd0;
      r_tag_m <= 7'd0;
      r_tag_w <= 7'd0;
      r_vld_e <= 1'b0;
      r_vld_m <= 1'b0;
      r_vld_w <= 1'b0;
    end else begin
      r_tag_e <= {tid_d, rd_d};
      r_vld_e <= w_accept;
      r_tag_m <= r_tag_e;
      r_vld_m <= r_vld_e & ~kill_e;
      r_tag_w <= r_tag_m;
      r_vld_w <= r_vld_m;
    end
  end

`ifdef SPARC_EXU_BYP_W2_EN
  logic [6:0] r_tag_w2;
  logic       r_vld_w2;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_tag_w2 <= 7'd0;
      r_vld_w2 <= 1'b0;
    end else begin
      r_tag_w2 <= r_tag_w;
      r_vld_w2 <= r_vld_w;
    end
  end

  assign w_tag_w2 = r_tag_w2;
  assign w_vld_w2 = r_vld_w2;
`else
  assign w_tag_w2 = 7'd0;
  assign w_vld_w2 = 1'b0;
`endif

  logic [2:0][4:0] w_rs;
  logic [2:0][4:0] w_sel;

  assign w_rs = {rs3_d, rs2_d, rs1_d};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      logic [6:0] w_q;
      logic [3:0] w_hit;

      assign w_q   = {tid_d, w_rs[gi]};
      assign w_hit = {w_vld_w2 & (w_q == w_tag_w2),
                      r_vld_w  & (w_q == r_tag_w),
                      r_vld_m  & (w_q == r_tag_m),
                      r_vld_e  & (w_q == r_tag_e)};

      // Youngest stage wins; source %g0 always reads the register file.
      assign w_sel[gi] = (w_rs[gi] == 5'd0) ? 5'b00001 :
                         w_hit[0]           ? 5'b00010 :
                         w_hit[1]           ? 5'b00100 :
                         w_hit[2]           ? 5'b01000 :
                         w_hit[3]           ? 5'b10000 :
                                              5'b00001;
    end
  endgenerate

  assign byp_rs1_sel_d = w_sel[0];
  assign byp_rs2_sel_d = w_sel[1];
  assign byp_rs3_sel_d = w_sel[2];
  assign tag_vld_ewm   = {w_vld_w2, r_vld_w, r_vld_m, r_vld_e};

endmodule

// File: tb/tb_sparc_exu_eclbyptag.sv
// Table-driven bench for sparc_exu_eclbyptag plus a mid-cycle asynchronous reset sequence.
// Expectations target the default build; SPARC_EXU_BYP_W2_EN adjusts the few W2-visible values.
module tb_sparc_exu_eclbyptag;

  logic       rclk;
  logic       arst_l;
  logic [1:0] tid_d;
  logic [4:0] rd_d;
  logic       wen_d;
  logic [4:0] rs1_d, rs2_d, rs3_d;
  logic       stall_d;
  logic       kill_e;
  logic [4:0] byp_rs1_sel_d, byp_rs2_sel_d, byp_rs3_sel_d;
  logic [3:0] tag_vld_ewm;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] R  = 5'b00001;
  localparam logic [4:0] E  = 5'b00010;
  localparam logic [4:0] M  = 5'b00100;
  localparam logic [4:0] W  = 5'b01000;
`ifdef SPARC_EXU_BYP_W2_EN
  localparam logic [4:0] ROW5_SEL = 5'b10000;
  localparam logic [3:0] VMASK    = 4'b0111;
`else
  localparam logic [4:0] ROW5_SEL = 5'b00001;
  localparam logic [3:0] VMASK    = 4'b1111;
`endif

  sparc_exu_eclbyptag dut (
    .rclk          (rclk),
    .arst_l        (arst_l),
    .tid_d         (tid_d),
    .rd_d          (rd_d),
    .wen_d         (wen_d),
    .rs1_d         (rs1_d),
    .rs2_d         (rs2_d),
    .rs3_d         (rs3_d),
    .stall_d       (stall_d),
    .kill_e        (kill_e),
    .byp_rs1_sel_d (byp_rs1_sel_d),
    .byp_rs2_sel_d (byp_rs2_sel_d),
    .byp_rs3_sel_d (byp_rs3_sel_d),
    .tag_vld_ewm   (tag_vld_ewm)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [1:0] tid;
    logic [4:0] rd;
    logic       wen, stall, kill;
    logic [4:0] rs1, rs2, rs3;
    logic [4:0] s1, s2, s3;
    logic [3:0] vld;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mkv(input logic [1:0] tid, input logic [4:0] rd, input logic wen,
                               input logic stall, input logic kill, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rs3, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] s3, input logic [3:0] vld);
    vec_t v;
    v.tid = tid; v.rd = rd; v.wen = wen; v.stall = stall; v.kill = kill;
    v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] tid, input logic [4:0] rd, input logic wen,
                       input logic stall, input logic kill, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rs3);
    tid_d = tid; rd_d = rd; wen_d = wen; stall_d = stall; kill_e = kill;
    rs1_d = rs1; rs2_d = rs2; rs3_d = rs3;
  endtask

  initial begin
    // tid rd wen stall kill | rs1 rs2 rs3 | sel1 sel2 sel3 vld
    vecs[0]  = mkv(2'd0, 5'd0,  1, 0, 0,  5'd5,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[0].wen = 1'b0;
    vecs[1]  = mkv(2'd1, 5'd5,  1, 0, 0,  5'd5,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[2]  = mkv(2'd1, 5'd0,  0, 0, 0,  5'd5,  5'd5,  5'd6, E, E, R, 4'b0001);
    vecs[3]  = mkv(2'd1, 5'd0,  0, 0, 0,  5'd5,  5'd0,  5'd0, M, R, R, 4'b0010);
    vecs[4]  = mkv(2'd1, 5'd0,  0, 0, 0,  5'd5,  5'd0,  5'd0, W, R, R, 4'b0100);
    vecs[5]  = mkv(2'd1, 5'd0,  0, 0, 0,  5'd5,  5'd0,  5'd0, ROW5_SEL, R, R, 4'b0000);
    vecs[6]  = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[7]  = mkv(2'd2, 5'd7,  1, 0, 0,  5'd0,  5'd7,  5'd0, R, R, R, 4'b0000);
    vecs[8]  = mkv(2'd2, 5'd7,  1, 0, 0,  5'd0,  5'd7,  5'd0, R, E, R, 4'b0001);
    vecs[9]  = mkv(2'd2, 5'd7,  1, 0, 0,  5'd0,  5'd7,  5'd0, R, E, R, 4'b0011);
    vecs[10] = mkv(2'd2, 5'd0,  0, 0, 0,  5'd0,  5'd7,  5'd0, R, E, R, 4'b0111);
    vecs[11] = mkv(2'd3, 5'd0,  0, 0, 0,  5'd7,  5'd7,  5'd7, R, R, R, 4'b0110);
    vecs[12] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0100);
    vecs[13] = mkv(2'd0, 5'd0,  1, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[14] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[15] = mkv(2'd0, 5'd9,  1, 1, 0,  5'd9,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[16] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd9,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[17] = mkv(2'd0, 5'd9,  1, 0, 0,  5'd9,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[18] = mkv(2'd0, 5'd0,  0, 0, 1,  5'd9,  5'd0,  5'd0, E, R, R, 4'b0001);
    vecs[19] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd9,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[20] = mkv(2'd3, 5'd11, 1, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[21] = mkv(2'd3, 5'd12, 1, 1, 1,  5'd11, 5'd12, 5'd0, E, R, R, 4'b0001);
    vecs[22] = mkv(2'd3, 5'd0,  0, 0, 0,  5'd11, 5'd12, 5'd0, R, R, R, 4'b0000);
    vecs[23] = mkv(2'd0, 5'd1,  1, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);
    vecs[24] = mkv(2'd0, 5'd2,  1, 0, 0,  5'd1,  5'd0,  5'd0, E, R, R, 4'b0001);
    vecs[25] = mkv(2'd0, 5'd3,  1, 0, 0,  5'd1,  5'd2,  5'd0, M, E, R, 4'b0011);
    vecs[26] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd1,  5'd2,  5'd3, W, M, E, 4'b0111);
    vecs[27] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd2,  5'd3, R, W, M, 4'b0110);
    vecs[28] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd0,  5'd3, R, R, W, 4'b0100);
    vecs[29] = mkv(2'd0, 5'd0,  0, 0, 0,  5'd0,  5'd0,  5'd0, R, R, R, 4'b0000);

    arst_l = 1'b0;
    drive(2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0);
    repeat (2) @(negedge rclk);
    #1;
    chk("reset_sel1", -1, byp_rs1_sel_d, R);
    chk("reset_sel2", -1, byp_rs2_sel_d, R);
    chk("reset_sel3", -1, byp_rs3_sel_d, R);
    chk("reset_vld", -1, {1'b0, tag_vld_ewm}, 5'b00000);
    $display("reset: sel1=%b sel2=%b sel3=%b vld=%b", byp_rs1_sel_d, byp_rs2_sel_d,
             byp_rs3_sel_d, tag_vld_ewm);
    @(negedge rclk);
    arst_l = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge rclk);
      drive(vecs[i].tid, vecs[i].rd, vecs[i].wen, vecs[i].stall, vecs[i].kill,
            vecs[i].rs1, vecs[i].rs2, vecs[i].rs3);
      #1;
      chk("sel1", i, byp_rs1_sel_d, vecs[i].s1);
      chk("sel2", i, byp_rs2_sel_d, vecs[i].s2);
      chk("sel3", i, byp_rs3_sel_d, vecs[i].s3);
      chk("vld", i, {1'b0, tag_vld_ewm & VMASK}, {1'b0, vecs[i].vld & VMASK});
      $display("row %0d: tid=%0d rd=%0d wen=%b stall=%b kill=%b rs=%0d/%0d/%0d -> sel=%b/%b/%b vld=%b",
               i, tid_d, rd_d, wen_d, stall_d, kill_e, rs1_d, rs2_d, rs3_d,
               byp_rs1_sel_d, byp_rs2_sel_d, byp_rs3_sel_d, tag_vld_ewm);
    end

    // Write r4, let it reach M, then pulse reset between clock edges.
    @(negedge rclk);
    drive(2'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0);
    #1 chk("arst_pre_d", 100, byp_rs1_sel_d, R);
    @(negedge rclk);
    wen_d = 1'b0;
    #1 chk("arst_pre_e", 101, byp_rs1_sel_d, E);
    @(posedge rclk);
    #2 chk("arst_pre_m", 102, byp_rs1_sel_d, M);
    chk("arst_pre_vld", 102, {1'b0, tag_vld_ewm & VMASK}, 5'b00010);
    #1 arst_l = 1'b0;
    #1 chk("arst_sel", 103, byp_rs1_sel_d, R);
    chk("arst_vld", 103, {1'b0, tag_vld_ewm}, 5'b00000);
    $display("mid-cycle reset: sel1=%b vld=%b", byp_rs1_sel_d, tag_vld_ewm);
    @(negedge rclk);
    arst_l = 1'b1;
    #1 chk("arst_rel_sel", 104, byp_rs1_sel_d, R);
    chk("arst_rel_vld", 104, {1'b0, tag_vld_ewm}, 5'b00000);
    @(negedge rclk);
    drive(2'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0);
    @(negedge rclk);
    wen_d = 1'b0;
    #1 chk("post_reset_e", 105, byp_rs1_sel_d, E);
    $display("post-reset write: sel1=%b vld=%b", byp_rs1_sel_d, tag_vld_ewm);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sparc_exu_eclbyptag.md
Name: sparc_exu_eclbyptag

Overview:
- Destination-tag pipeline for EXU register bypass control.
- Tracks the 7-bit write tag {tid[1:0], rd[4:0]} and a valid bit for the E, M and W stages. An optional W2 stage is added by macro.
- Compares each decode-stage source tag against every tracked tag with 7-bit equality compares and emits one-hot bypass selects per source.
- Sits directly upstream of the EXU operand bypass muxes and feeds them.

Parameters:
- NONE, -, all widths fixed: tag = 7 bits; select width = 5.

Ports:
- rclk  input  1  core clock; all state updates on the rising edge.
- arst_l  input  1  asynchronous active-low reset.
- tid_d  input  2  thread id of the decode-stage instruction.
- rd_d  input  5  destination register of the decode-stage instruction.
- wen_d  input  1  decode-stage instruction writes rd_d.
- rs1_d  input  5  source 1 register number.
- rs2_d  input  5  source 2 register number.
- rs3_d  input  5  source 3 register number.
- stall_d  input  1  decode-stage instruction held; it does not advance this cycle.
- kill_e  input  1  squash the instruction currently in E.
- byp_rs1_sel_d  output  5  one-hot {w2,w,m,e,rf} select for source 1.
- byp_rs2_sel_d  output  5  same encoding, source 2.
- byp_rs3_sel_d  output  5  same encoding, source 3.
- tag_vld_ewm  output  4  {w2,w,m,e} valid bits, for debug and the verification bench.

Behaviour:
- Reset (arst_l=0, asynchronous):
  - all valid bits clear; tags clear to 0.
  - every byp_rsN_sel_d = 5'b00001 (rf); tag_vld_ewm = 4'b0000.
  - Deassertion takes effect at the next rclk edge.
- Stage advance, every rclk edge:
  - E <= {tid_d, rd_d}; valid_e <= wen_d & ~stall_d & (rd_d != 0).
  - M <= E; valid_m <= valid_e & ~kill_e.
  - W <= M; valid_w <= valid_m.
  - Stalls do not hold E/M/W: a stall inserts a bubble into E while older stages keep draining.
- Latency: an instruction accepted in cycle n occupies E at n+1, M at n+2, W at n+3, and is gone at n+4.
- Match for source rsN:
  - match_X = valid_X & ({tid_d, rsN_d} == tag_X), using a full 7-bit equality.
  - Any rsN_d == 0 forces the select to rf; %g0 never bypasses.
- Priority is youngest first: E > M > W (> W2). Exactly one select bit is set; with no match the select is rf.
- Selects are combinational from registered state plus the D inputs, with no added latency.
- Threads: equal rd with a different tid never matches.
- kill_e together with stall_d: the E entry is still killed; the bubble still enters E.
- Mid-operation reset clears all in-flight tags immediately; selects return to rf in the same cycle, asynchronously.
- Back-to-back writes of the same tag: the youngest stage wins.
- Invariant: a set valid bit implies its rd field != 0.

Optional Feature:
- Macro: SPARC_EXU_BYP_W2_EN.
- Defined:
  - a W2 stage is added: W2 <= W; valid_w2 <= valid_w.
  - select bit 4 becomes live at lowest priority.
  - an accepted instruction is then gone at n+5.
  - tag_vld_ewm[3] reports valid_w2.
- Undefined:
  - no W2 state is built.
  - select bit 4 and tag_vld_ewm[3] are tied 0.

Test Plan:
- Reset, then rs1_d=5, tid_d=0, no writes -> all selects 5'b00001; tag_vld_ewm=0.
- Cycle 0: wen_d=1, rd_d=5, tid_d=1. Then hold rs1_d=5, tid_d=1 -> sel=00010 in cycle 1, 00100 in cycle 2, 01000 in cycle 3, 00001 in cycle 4. With SPARC_EXU_BYP_W2_EN, cycle 4 gives 10000 and cycle 5 gives 00001.
- Three consecutive writes to r7 (tid 2), then rs2_d=7, tid_d=2 -> sel=00010 (E wins). Same query with tid_d=3 -> sel=00001.
- wen_d=1, rd_d=0 -> no valid entry; rs3_d=0 -> always 00001.
- Write r9 with stall_d=1 -> E not loaded, rs1=9 stays at 00001. Write r9 with stall_d=0, then kill_e=1 in the next cycle -> sel=00010 in cycle 1, then 00001 from cycle 2 onward.
- Write r4, then pulse arst_l low mid-cycle while the entry is in M -> selects go to 00001 immediately; tag_vld_ewm=0.
